// File: rtl/aq_fcnvt_ex3_wb_if.sv
// Bundle of the ex3 writeback stage signals.
//   ex2 side : fcnvt_ex2_pipedown, ex2_dest_l64, fcnvt_ex2_result,
//              fcnvt_ex2_vreg, fcnvt_ex2_fflags, vpu_fcnvt_flush
//   rf side  : vpu_rf_wb_grant (in), fcnvt_wb_req / vreg / data /
//              fflags / last (out)
//   control  : vpu_group_1_xx_ex3_stall (out)
//   debug    : dbg_count, dbg_hi_beat (buffer occupancy and beat state)
// Modport slave is the stage itself; master is whoever drives ex2 and the
// register file grant.
// Handshake: a writeback beat transfers on a clock edge where
// fcnvt_wb_req=1 and vpu_rf_wb_grant=1. While grant is low, req and every
// beat output hold. A grant seen while req=0 has no effect.
interface aq_fcnvt_ex3_wb_if #(
  parameter int DATA_W = 64,
  parameter int VREG_W = 5
);
  logic                  fcnvt_ex2_pipedown;
  logic                  ex2_dest_l64;
  logic [2*DATA_W-1:0]   fcnvt_ex2_result;
  logic [VREG_W-1:0]     fcnvt_ex2_vreg;
  logic [4:0]            fcnvt_ex2_fflags;
  logic                  vpu_fcnvt_flush;
  logic                  vpu_rf_wb_grant;
  logic                  fcnvt_wb_req;
  logic [VREG_W-1:0]     fcnvt_wb_vreg;
  logic [DATA_W-1:0]     fcnvt_wb_data;
  logic [4:0]            fcnvt_wb_fflags;
  logic                  fcnvt_wb_last;
  logic                  vpu_group_1_xx_ex3_stall;
  logic [1:0]            dbg_count;
  logic                  dbg_hi_beat;

  modport slave (
    input  fcnvt_ex2_pipedown, ex2_dest_l64, fcnvt_ex2_result,
           fcnvt_ex2_vreg, fcnvt_ex2_fflags, vpu_fcnvt_flush, vpu_rf_wb_grant,
    output fcnvt_wb_req, fcnvt_wb_vreg, fcnvt_wb_data, fcnvt_wb_fflags,
           fcnvt_wb_last, vpu_group_1_xx_ex3_stall, dbg_count, dbg_hi_beat
  );

  modport master (
    output fcnvt_ex2_pipedown, ex2_dest_l64, fcnvt_ex2_result,
           fcnvt_ex2_vreg, fcnvt_ex2_fflags, vpu_fcnvt_flush, vpu_rf_wb_grant,
    input  fcnvt_wb_req, fcnvt_wb_vreg, fcnvt_wb_data, fcnvt_wb_fflags,
           fcnvt_wb_last, vpu_group_1_xx_ex3_stall, dbg_count, dbg_hi_beat
  );
endinterface

// File: rtl/aq_fcnvt_ex3_wb.sv
// Ex3 writeback stage of the vector float-convert unit.
// Buffers up to two convert results from ex2 and drains them to the vector
// register file, one beat per normal result and two beats (low half, then
// high half to vreg+1) per widening 64-bit-element result.
// Ports:
//   forever_cpuclk : clock
//   cpurst         : synchronous active-high reset
//   bus            : aq_fcnvt_ex3_wb_if.slave (ex2 push, rf writeback,
//                    stall to pipe control, debug state)
module aq_fcnvt_ex3_wb #(
  parameter int DATA_W = 64,
  parameter int VREG_W = 5
) (
  input logic              forever_cpuclk,
  input logic              cpurst,
  aq_fcnvt_ex3_wb_if.slave bus
);

  typedef enum logic {BEAT_LO = 1'b0, BEAT_HI = 1'b1} beat_e;

  logic [2*DATA_W-1:0] ent_result [2];
  logic [VREG_W-1:0]   ent_vreg   [2];
  logic [4:0]          ent_fflags [2];
  logic                ent_l64    [2];

  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  beat_e      beat_q;
  beat_e      beat_d;

  logic req;
  logic full;
  logic push;
  logic fire;
  logic pop;

  assign req  = (count != 2'd0);
  assign full = (count == 2'd2);
  // A push into a full buffer is dropped; ex2 is expected to honour stall.
  assign push = bus.fcnvt_ex2_pipedown && !full;
  assign fire = req && bus.vpu_rf_wb_grant;

  // Beat sequencing: only a low beat of a widening head advances to HI;
  // every other completed beat retires the head entry.
  always_comb begin
    beat_d = beat_q;
    pop    = 1'b0;
    if (fire) begin
      if (beat_q == BEAT_LO && ent_l64[rd_ptr]) begin
        beat_d = BEAT_HI;
      end else begin
        beat_d = BEAT_LO;
        pop    = 1'b1;
      end
    end
  end

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst || bus.vpu_fcnvt_flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      beat_q <= BEAT_LO;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count  <= count + {1'b0, push} - {1'b0, pop};
      beat_q <= beat_d;
    end
  end

  // Payload storage carries no reset; occupancy alone says what is valid.
  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst && !bus.vpu_fcnvt_flush && push) begin
      ent_result[wr_ptr] <= bus.fcnvt_ex2_result;
      ent_vreg[wr_ptr]   <= bus.fcnvt_ex2_vreg;
      ent_fflags[wr_ptr] <= bus.fcnvt_ex2_fflags;
      ent_l64[wr_ptr]    <= bus.ex2_dest_l64;
    end
  end

  logic [DATA_W-1:0] wb_data;
  logic [VREG_W-1:0] wb_vreg;
  logic [4:0]        wb_fflags;
  logic              wb_last;

  always_comb begin
    wb_data   = '0;
    wb_vreg   = '0;
    wb_fflags = '0;
    wb_last   = 1'b0;
    if (req) begin
      if (beat_q == BEAT_HI) begin
        wb_data = ent_result[rd_ptr][2*DATA_W-1:DATA_W];
        // High half lands in the next register; 31 wraps to 0.
        wb_vreg = ent_vreg[rd_ptr] + {{(VREG_W-1){1'b0}}, 1'b1};
        wb_last = 1'b1;
      end else begin
        wb_data = ent_result[rd_ptr][DATA_W-1:0];
        wb_vreg = ent_vreg[rd_ptr];
        wb_last = !ent_l64[rd_ptr];
      end
      // Flags belong to the whole result, so only the final beat carries them.
      if (wb_last) wb_fflags = ent_fflags[rd_ptr];
    end
  end

  assign bus.fcnvt_wb_req             = req;
  assign bus.fcnvt_wb_data            = wb_data;
  assign bus.fcnvt_wb_vreg            = wb_vreg;
  assign bus.fcnvt_wb_fflags          = wb_fflags;
  assign bus.fcnvt_wb_last            = wb_last;
  assign bus.vpu_group_1_xx_ex3_stall = full;
  assign bus.dbg_count                = count;
  assign bus.dbg_hi_beat              = (beat_q == BEAT_HI);

endmodule

// File: tb/tb_aq_fcnvt_ex3_wb.sv
// Testbench for aq_fcnvt_ex3_wb: directed scenarios with constant
// expectations followed by randomized traffic checked against a queue model.
module tb_aq_fcnvt_ex3_wb;
  localparam int DW = 64;
  localparam int VW = 5;
  // {req, vreg, data, fflags, last, stall, count, hi}
  localparam int OW = 1 + VW + DW + 5 + 1 + 1 + 2 + 1;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aq_fcnvt_ex3_wb_if #(.DATA_W(DW), .VREG_W(VW)) bus ();
  aq_fcnvt_ex3_wb #(.DATA_W(DW), .VREG_W(VW)) dut (
    .forever_cpuclk(clk),
    .cpurst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  // reference model: queue of pending results plus "high half next" flag
  typedef struct packed {
    logic [2*DW-1:0] result;
    logic [VW-1:0]   vreg;
    logic [4:0]      fflags;
    logic            l64;
  } ent_t;
  ent_t mq[$];
  bit   mhi = 1'b0;

  function automatic logic [OW-1:0] pack(logic req, logic [VW-1:0] vreg,
      logic [DW-1:0] data, logic [4:0] ff, logic last, logic stall,
      logic [1:0] cnt, logic hi);
    return {req, vreg, data, ff, last, stall, cnt, hi};
  endfunction

  function automatic logic [OW-1:0] obs();
    return {bus.fcnvt_wb_req, bus.fcnvt_wb_vreg, bus.fcnvt_wb_data,
            bus.fcnvt_wb_fflags, bus.fcnvt_wb_last,
            bus.vpu_group_1_xx_ex3_stall, bus.dbg_count, bus.dbg_hi_beat};
  endfunction

  function automatic logic [OW-1:0] model_out();
    ent_t h;
    logic [VW-1:0] v;
    logic [DW-1:0] d;
    logic last;
    int n;
    n = mq.size();
    if (n == 0) return '0;
    h = mq[0];
    if (mhi) begin
      d = h.result[2*DW-1:DW];
      v = VW'((int'(h.vreg) + 1) % (1 << VW));
      last = 1'b1;
    end else begin
      d = h.result[DW-1:0];
      v = h.vreg;
      last = !h.l64;
    end
    return pack(1'b1, v, d, last ? h.fflags : 5'd0, last, n == 2, 2'(n), mhi);
  endfunction

  // advance the model with the inputs present at a clock edge
  task automatic model_step();
    int n;
    ent_t e;
    n = mq.size();
    if (rst || bus.vpu_fcnvt_flush) begin
      mq.delete();
      mhi = 1'b0;
      return;
    end
    if (n > 0 && bus.vpu_rf_wb_grant) begin
      if (!mhi && mq[0].l64) mhi = 1'b1;
      else begin
        void'(mq.pop_front());
        mhi = 1'b0;
      end
    end
    if (bus.fcnvt_ex2_pipedown) begin
      if (n == 2) begin
        bad++;
        $display("FAIL illegal_push obs=push_when_full exp=no_push");
      end else begin
        e.result = bus.fcnvt_ex2_result;
        e.vreg   = bus.fcnvt_ex2_vreg;
        e.fflags = bus.fcnvt_ex2_fflags;
        e.l64    = bus.ex2_dest_l64;
        mq.push_back(e);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // driver tasks
  task automatic drive(logic pd, logic l64, logic [2*DW-1:0] res,
      logic [VW-1:0] vreg, logic [4:0] ff, logic flush, logic grant);
    bus.fcnvt_ex2_pipedown = pd;
    bus.ex2_dest_l64       = l64;
    bus.fcnvt_ex2_result   = res;
    bus.fcnvt_ex2_vreg     = vreg;
    bus.fcnvt_ex2_fflags   = ff;
    bus.vpu_fcnvt_flush    = flush;
    bus.vpu_rf_wb_grant    = grant;
  endtask

  task automatic idle(logic grant);
    drive(1'b0, 1'b0, '0, '0, '0, 1'b0, grant);
  endtask

  localparam logic [2*DW-1:0] RES_SINGLE = {64'h0, 64'h3FF0_0000_0000_0000};
  localparam logic [2*DW-1:0] RES_WIDE   = {64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555};

  task automatic test_reset();
    logic [OW-1:0] o;
    idle(1'b0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    o = obs();
    total++;
    if (o !== '0) begin bad++; $display("FAIL reset obs=%h exp=%h", o, '0); end
  endtask

  task automatic test_single_beat();
    logic [OW-1:0] o, e;
    drive(1'b1, 1'b0, RES_SINGLE, 5'd3, 5'h01, 1'b0, 1'b1);
    tick();
    idle(1'b1);
    o = obs();
    e = pack(1'b1, 5'd3, 64'h3FF0_0000_0000_0000, 5'h01, 1'b1, 1'b0, 2'd1, 1'b0);
    total++;
    if (o !== e) begin bad++; $display("FAIL single_n1 obs=%h exp=%h", o, e); end
    tick();
    o = obs();
    total++;
    if (o !== '0) begin bad++; $display("FAIL single_n2 obs=%h exp=%h", o, '0); end
    idle(1'b0);
  endtask

  task automatic test_widen_wrap();
    logic [OW-1:0] o, e;
    drive(1'b1, 1'b1, RES_WIDE, 5'd31, 5'h10, 1'b0, 1'b0);
    tick();
    idle(1'b0);
    e = pack(1'b1, 5'd31, 64'h5555_5555_5555_5555, 5'h00, 1'b0, 1'b0, 2'd1, 1'b0);
    o = obs();
    total++;
    if (o !== e) begin bad++; $display("FAIL widen_beat1 obs=%h exp=%h", o, e); end
    tick();
    o = obs();
    total++;
    if (o !== e) begin bad++; $display("FAIL widen_hold obs=%h exp=%h", o, e); end
    idle(1'b1);
    tick();
    o = obs();
    e = pack(1'b1, 5'd0, 64'hAAAA_AAAA_AAAA_AAAA, 5'h10, 1'b1, 1'b0, 2'd1, 1'b1);
    total++;
    if (o !== e) begin bad++; $display("FAIL widen_beat2 obs=%h exp=%h", o, e); end
    tick();
    o = obs();
    total++;
    if (o !== '0) begin bad++; $display("FAIL widen_done obs=%h exp=%h", o, '0); end
    idle(1'b0);
  endtask

  task automatic test_back_pressure();
    logic [OW-1:0] o, e;
    drive(1'b1, 1'b0, 128'hA, 5'd5, 5'h02, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b0, 128'hB, 5'd6, 5'h04, 1'b0, 1'b0);
    tick();
    idle(1'b0);
    o = obs();
    e = pack(1'b1, 5'd5, 64'hA, 5'h02, 1'b1, 1'b1, 2'd2, 1'b0);
    total++;
    if (o !== e) begin bad++; $display("FAIL bp_full obs=%h exp=%h", o, e); end
    idle(1'b1);
    tick();
    idle(1'b0);
    o = obs();
    e = pack(1'b1, 5'd6, 64'hB, 5'h04, 1'b1, 1'b0, 2'd1, 1'b0);
    total++;
    if (o !== e) begin bad++; $display("FAIL bp_after_pop obs=%h exp=%h", o, e); end
    idle(1'b1);
    tick();
    idle(1'b0);
    o = obs();
    total++;
    if (o !== '0) begin bad++; $display("FAIL bp_drain obs=%h exp=%h", o, '0); end
  endtask

  task automatic test_back_to_back();
    logic [OW-1:0] o, e;
    drive(1'b1, 1'b0, 128'hD, 5'd7, 5'h03, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b0, 128'hC, 5'd8, 5'h05, 1'b0, 1'b1);
    o = obs();
    e = pack(1'b1, 5'd7, 64'hD, 5'h03, 1'b1, 1'b0, 2'd1, 1'b0);
    total++;
    if (o !== e) begin bad++; $display("FAIL overlap_before obs=%h exp=%h", o, e); end
    tick();
    idle(1'b1);
    o = obs();
    e = pack(1'b1, 5'd8, 64'hC, 5'h05, 1'b1, 1'b0, 2'd1, 1'b0);
    total++;
    if (o !== e) begin bad++; $display("FAIL overlap_after obs=%h exp=%h", o, e); end
    tick();
    idle(1'b0);
    o = obs();
    total++;
    if (o !== '0) begin bad++; $display("FAIL overlap_drain obs=%h exp=%h", o, '0); end
  endtask

  // leaves the buffer full with a widening head in its high beat
  task automatic fill_to_hi();
    drive(1'b1, 1'b1, {64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888},
          5'd10, 5'h08, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b0, 128'h12, 5'd12, 5'h01, 1'b0, 1'b0);
    tick();
    idle(1'b1);
    tick();
    idle(1'b0);
  endtask

  task automatic test_flush_mid_l64();
    logic [OW-1:0] o, e;
    fill_to_hi();
    o = obs();
    e = pack(1'b1, 5'd11, 64'h1111_2222_3333_4444, 5'h08, 1'b1, 1'b1, 2'd2, 1'b1);
    total++;
    if (o !== e) begin bad++; $display("FAIL flush_pre_hi obs=%h exp=%h", o, e); end
    drive(1'b1, 1'b0, 128'h99, 5'd20, 5'h1F, 1'b1, 1'b1);
    tick();
    idle(1'b0);
    o = obs();
    total++;
    if (o !== '0) begin bad++; $display("FAIL flush_next obs=%h exp=%h", o, '0); end
    tick();
    o = obs();
    total++;
    if (o !== '0) begin bad++; $display("FAIL flush_discard obs=%h exp=%h", o, '0); end
  endtask

  task automatic test_reset_mid();
    logic [OW-1:0] o;
    fill_to_hi();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    o = obs();
    total++;
    if (o !== '0) begin bad++; $display("FAIL reset_mid obs=%h exp=%h", o, '0); end
  endtask

  task automatic test_random();
    logic [OW-1:0] o, e;
    logic pd;
    for (int i = 0; i < 600; i++) begin
      pd = (mq.size() < 2) && ($urandom_range(0, 2) != 0);
      drive(pd, 1'($urandom_range(0, 1)),
            {$urandom, $urandom, $urandom, $urandom},
            VW'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
            $urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 99) == 0);
      tick();
      rst = 1'b0;
      o = obs();
      e = model_out();
      total++;
      if (o !== e) begin bad++; $display("FAIL random_%0d obs=%h exp=%h", i, o, e); end
    end
    idle(1'b0);
  endtask

  initial begin
    idle(1'b0);
    test_reset();
    test_single_beat();
    test_widen_wrap();
    test_back_pressure();
    test_back_to_back();
    test_flush_mid_l64();
    test_reset_mid();
    test_single_beat();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
